// File: rtl/hub75_capture_if.sv
`default_nettype none
// ============================================================================
// Module  : hub75_capture_if
// Purpose : Pixel write bus between the HUB75 receiver and the frame store.
// Rev     : 1.0
// ============================================================================
interface hub75_capture_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 24
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input  wr_ready);
    modport slave  (input  wr_valid, input  wr_addr, input  wr_data, output wr_ready);
endinterface
`default_nettype wire

// File: rtl/hub75_capture.sv
`default_nettype none
// ============================================================================
// Module  : hub75_capture
// Purpose : HUB75 panel-bus receiver; rebuilds bit-plane rows into {y,x} pixel
//           writes. Define HUB75_RX_RGB565_EN for RGB565 write data.
// Rev     : 1.0
// ============================================================================
module hub75_capture #(
    parameter int WIDTH       = 64,
    parameter int HEIGHT      = 64,
    parameter int COLOR_DEPTH = 8,
    parameter int SYNC_STAGES = 2
) (
    input  wire             display_clock,
    input  wire             resetn,
    input  wire             panel_r0,
    input  wire             panel_g0,
    input  wire             panel_b0,
    input  wire             panel_r1,
    input  wire             panel_g1,
    input  wire             panel_b1,
    input  wire             panel_a,
    input  wire             panel_b,
    input  wire             panel_c,
    input  wire             panel_d,
    input  wire             panel_e,
    input  wire             panel_clk,
    input  wire             panel_stb,
    hub75_capture_if.master wr,
    output logic            frame_done,
    output logic            err_short,
    output logic            err_overrun,
    input  wire             err_clr
);
    localparam int c_XW    = $clog2(WIDTH);
    localparam int c_YW    = $clog2(HEIGHT);
    localparam int c_RW    = c_YW - 1;
    localparam int c_CW    = $clog2(WIDTH + 1);
    localparam int c_PW    = (COLOR_DEPTH > 1) ? $clog2(COLOR_DEPTH) : 1;
    localparam int c_PIX_W = 6 * COLOR_DEPTH;

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_EMIT = 1'b1} t_wb_state;

    logic [12:0]         r_sync [SYNC_STAGES];
    logic                r_pclk_d, r_pstb_d;
    logic [c_CW-1:0]     r_col;
    logic [c_PW-1:0]     r_plane;
    logic                r_line_ok, r_drop, r_wbank;
    logic [c_RW:0]       r_last_row;
    logic                r_err_short, r_err_overrun;
    logic [5:0]          r_line [WIDTH];
    logic [c_PIX_W-1:0]  r_mem [2*WIDTH];

    t_wb_state           r_state;
    logic                r_rd_bank, r_half, r_wr_valid, r_frame_done;
    logic [c_XW-1:0]     r_x;
    logic [c_PIX_W-1:0]  r_pix;
    logic [c_XW+c_YW-1:0] r_wr_addr;
    logic [23:0]         r_wr_data;
    logic [1:0]          r_busy;
    logic [c_RW-1:0]     r_bank_row [2];

    logic [12:0]     w_s;
    logic [5:0]      w_bits;
    logic [4:0]      w_addr5;
    logic [c_RW-1:0] w_row;
    logic            w_clk_rise, w_stb_rise, w_col_store, w_len_ok;
    logic [c_CW-1:0] w_col_next;
    logic [c_PW-1:0] w_plane;
    logic            w_ok, w_drop, w_commit, w_complete, w_hand;
    logic [c_YW-1:0] w_y0, w_y1;

    // Colour bits per plane: [5]=r0 [4]=g0 [3]=b0 [2]=r1 [1]=g1 [0]=b1
    function automatic logic [23:0] f_fmt(input logic [c_PIX_W-1:0] pix, input logic half);
        logic [7:0] r, g, b;
        int         off;
        r   = '0;
        g   = '0;
        b   = '0;
        off = half ? 0 : 3;
        for (int p = 0; p < COLOR_DEPTH; p++) begin
            r[8-COLOR_DEPTH+p] = pix[p*6 + off + 2];
            g[8-COLOR_DEPTH+p] = pix[p*6 + off + 1];
            b[8-COLOR_DEPTH+p] = pix[p*6 + off];
        end
`ifdef HUB75_RX_RGB565_EN
        return {8'h00, b[7:3], g[7:2], r[7:3]};
`else
        return {r, g, b};
`endif
    endfunction

    always_ff @(posedge display_clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= {panel_stb, panel_clk, panel_e, panel_d, panel_c, panel_b, panel_a,
                          panel_r0, panel_g0, panel_b0, panel_r1, panel_g1, panel_b1};
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    assign w_s        = r_sync[SYNC_STAGES-1];
    assign w_bits     = w_s[5:0];
    assign w_addr5    = w_s[10:6];
    assign w_row      = w_addr5[c_RW-1:0];
    assign w_clk_rise = w_s[11] & ~r_pclk_d;
    assign w_stb_rise = w_s[12] & ~r_pstb_d;

    // A same-cycle CLK is folded in before the STB decision
    always_comb begin
        w_col_store = w_clk_rise && (r_col < c_CW'(WIDTH));
        w_col_next  = r_col + (w_col_store ? c_CW'(1) : c_CW'(0));
        w_len_ok    = (w_col_next == c_CW'(WIDTH));
        w_plane     = r_plane;
        w_ok        = 1'b0;
        w_drop      = r_drop;
        if ({1'b0, w_row} != r_last_row) begin
            w_plane = '0;
            w_ok    = 1'b1;
            w_drop  = r_busy[r_wbank];
        end else if (r_line_ok && (r_plane != c_PW'(COLOR_DEPTH-1))) begin
            w_plane = r_plane + c_PW'(1);
            w_ok    = 1'b1;
        end
        w_commit   = w_stb_rise && w_len_ok && w_ok && !w_drop;
        w_complete = w_stb_rise && w_len_ok && w_ok && (w_plane == c_PW'(COLOR_DEPTH-1));
        w_hand     = w_complete && !w_drop;
    end

    always_ff @(posedge display_clock or negedge resetn) begin
        if (!resetn) begin
            r_pclk_d      <= 1'b0;
            r_pstb_d      <= 1'b0;
            r_col         <= '0;
            r_plane       <= '0;
            r_line_ok     <= 1'b0;
            r_drop        <= 1'b0;
            r_last_row    <= '1;
            r_wbank       <= 1'b0;
            r_err_short   <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            r_pclk_d <= w_s[11];
            r_pstb_d <= w_s[12];
            if (err_clr) begin
                r_err_short   <= 1'b0;
                r_err_overrun <= 1'b0;
            end
            if (w_stb_rise) begin
                r_col <= '0;
                if (!w_len_ok) begin
                    r_err_short <= 1'b1;
                    r_plane     <= '0;
                    r_line_ok   <= 1'b0;
                    r_last_row  <= '1;
                end else begin
                    r_plane    <= w_plane;
                    r_line_ok  <= w_ok;
                    r_drop     <= w_drop;
                    r_last_row <= {1'b0, w_row};
                    if (w_complete && w_drop) r_err_overrun <= 1'b1;
                    if (w_hand) r_wbank <= ~r_wbank;
                end
            end else begin
                r_col <= w_col_next;
            end
        end
    end

    // Lines shift into a buffer and land in the bank as a whole plane on STB
    always_ff @(posedge display_clock) begin
        if (w_col_store) r_line[r_col[c_XW-1:0]] <= w_bits;
        if (w_commit) begin
            for (int c = 0; c < WIDTH; c++)
                r_mem[{r_wbank, c_XW'(c)}][6*int'(w_plane) +: 6] <=
                    (w_col_store && (r_col == c_CW'(c))) ? w_bits : r_line[c];
        end
    end

    assign w_y0 = {1'b0, r_bank_row[r_rd_bank]};
    assign w_y1 = {1'b1, r_bank_row[r_rd_bank]};

    always_ff @(posedge display_clock or negedge resetn) begin
        if (!resetn) begin
            r_state       <= S_IDLE;
            r_rd_bank     <= 1'b0;
            r_x           <= '0;
            r_half        <= 1'b0;
            r_pix         <= '0;
            r_wr_valid    <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_frame_done  <= 1'b0;
            r_busy        <= 2'b00;
            r_bank_row[0] <= '0;
            r_bank_row[1] <= '0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_hand) begin
                r_busy[r_wbank]     <= 1'b1;
                r_bank_row[r_wbank] <= w_row;
            end
            case (r_state)
                S_IDLE: begin
                    if (r_busy[r_rd_bank]) begin
                        r_pix   <= r_mem[{r_rd_bank, c_XW'(0)}];
                        r_x     <= '0;
                        r_half  <= 1'b0;
                        r_state <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (!r_wr_valid) begin
                        r_wr_valid <= 1'b1;
                        r_wr_addr  <= {w_y0, r_x};
                        r_wr_data  <= f_fmt(r_pix, 1'b0);
                    end else if (wr.wr_ready) begin
                        if (!r_half) begin
                            // Prefetch the next column while the bottom half is on the bus
                            r_half    <= 1'b1;
                            r_wr_addr <= {w_y1, r_x};
                            r_wr_data <= f_fmt(r_pix, 1'b1);
                            r_pix     <= r_mem[{r_rd_bank, r_x + c_XW'(1)}];
                        end else if (r_x == c_XW'(WIDTH-1)) begin
                            r_wr_valid        <= 1'b0;
                            r_busy[r_rd_bank] <= 1'b0;
                            r_rd_bank         <= ~r_rd_bank;
                            r_state           <= S_IDLE;
                            r_frame_done      <= (r_bank_row[r_rd_bank] == c_RW'(HEIGHT/2-1));
                        end else begin
                            r_x       <= r_x + c_XW'(1);
                            r_half    <= 1'b0;
                            r_wr_addr <= {w_y0, r_x + c_XW'(1)};
                            r_wr_data <= f_fmt(r_pix, 1'b0);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign wr.wr_valid = r_wr_valid;
    assign wr.wr_addr  = r_wr_addr;
    assign wr.wr_data  = r_wr_data;
    assign frame_done  = r_frame_done;
    assign err_short   = r_err_short;
    assign err_overrun = r_err_overrun;
endmodule
`default_nettype wire

// File: tb/tb_hub75_capture.sv
`default_nettype none
// ============================================================================
// Module  : tb_hub75_capture
// Purpose : Randomized HUB75 row stimulus checked against a pixel-level model.
// Rev     : 1.0
// ============================================================================
module tb_hub75_capture;
    localparam int W  = 64;
    localparam int H  = 64;
    localparam int CD = 8;
`ifdef HUB75_RX_RGB565_EN
    localparam logic [23:0] c_PIN = 24'h0001F4;
`else
    localparam logic [23:0] c_PIN = 24'hA53C01;
`endif

    logic display_clock = 1'b0;
    always #5 display_clock = ~display_clock;

    logic resetn, r0, g0, b0, r1, g1, b1, pa, pb, pc, pd, pe, pclk, pstb, err_clr;
    logic frame_done, err_short, err_overrun;

    hub75_capture_if #(.ADDR_W(12), .DATA_W(24)) bus();

    hub75_capture #(.WIDTH(W), .HEIGHT(H), .COLOR_DEPTH(CD), .SYNC_STAGES(2)) dut (
        .display_clock(display_clock), .resetn(resetn),
        .panel_r0(r0), .panel_g0(g0), .panel_b0(b0),
        .panel_r1(r1), .panel_g1(g1), .panel_b1(b1),
        .panel_a(pa), .panel_b(pb), .panel_c(pc), .panel_d(pd), .panel_e(pe),
        .panel_clk(pclk), .panel_stb(pstb),
        .wr(bus.master),
        .frame_done(frame_done), .err_short(err_short), .err_overrun(err_overrun),
        .err_clr(err_clr)
    );

    int errors = 0;
    int checks = 0;
    int accepts = 0;
    int fd_count = 0;
    int mode = 1;
    bit pin_on = 1'b0;
    logic [35:0] exp_q[$];
    logic [23:0] top [W];
    logic [23:0] bot [W];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [23:0] fmt(input logic [23:0] c);
`ifdef HUB75_RX_RGB565_EN
        return {8'h00, c[7:3], c[15:10], c[23:19]};
`else
        return c;
`endif
    endfunction

    task automatic drive_line(input int row, input int p, input int n);
        logic [4:0] a;
        a = 5'(row);
        {pe, pd, pc, pb, pa} = a;
        for (int x = 0; x < n; x++) begin
            r0 = top[x][16+p]; g0 = top[x][8+p]; b0 = top[x][p];
            r1 = bot[x][16+p]; g1 = bot[x][8+p]; b1 = bot[x][p];
            pclk = 1'b0;
            repeat (2) @(negedge display_clock);
            pclk = 1'b1;
            repeat (2) @(negedge display_clock);
        end
        pclk = 1'b0;
        pstb = 1'b1;
        repeat (2) @(negedge display_clock);
        pstb = 1'b0;
        repeat (2) @(negedge display_clock);
    endtask

    task automatic drive_row(input int row, input bit emit);
        for (int x = 0; x < W; x++) begin
            top[x] = 24'($urandom);
            bot[x] = 24'($urandom);
        end
        if (pin_on && row == 5) top[3] = 24'hA53C01;
        if (emit) begin
            for (int x = 0; x < W; x++) begin
                exp_q.push_back({6'(row), 6'(x), fmt(top[x])});
                exp_q.push_back({6'(row + H/2), 6'(x), fmt(bot[x])});
            end
        end
        for (int p = 0; p < CD; p++) drive_line(row, p, W);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            @(negedge display_clock);
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
        repeat (30) @(negedge display_clock);
    endtask

    // Output checker: stall stability, frame_done timing, beat order/content
    initial begin : g_compare
        bit          prev_stall, expect_fd, pin_next, acc;
        logic [11:0] prev_addr;
        logic [23:0] prev_data;
        logic [35:0] e;
        prev_stall = 0; expect_fd = 0; pin_next = 0;
        prev_addr = '0; prev_data = '0;
        bus.wr_ready = 1'b1;
        forever begin
            @(negedge display_clock);
            if (!resetn) begin
                prev_stall = 0;
                expect_fd  = 0;
            end else begin
                if (prev_stall)
                    chk("stall_hold", {bus.wr_valid, bus.wr_addr, bus.wr_data},
                        {1'b1, prev_addr, prev_data});
                if (frame_done || expect_fd) chk("frame_done", frame_done, expect_fd);
                if (frame_done) fd_count++;
                expect_fd = 0;
            end
            bus.wr_ready = (mode == 1) ? 1'b1 : (mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
            if (resetn) begin
                acc = bus.wr_valid && bus.wr_ready;
                if (acc) begin
                    accepts++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_beat: got addr %0h data %0h, required no beat",
                                 bus.wr_addr, bus.wr_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat", {bus.wr_addr, bus.wr_data}, e);
                        if (pin_next) begin
                            chk("pin_half1_addr", bus.wr_addr, 12'h943);
                            pin_next = 0;
                        end else if (pin_on && e[35:24] == 12'h143) begin
                            chk("pin_data", bus.wr_data, c_PIN);
                            pin_next = 1;
                        end
                        expect_fd = (e[35:24] == 12'hFFF);
                    end
                end
                prev_stall = bus.wr_valid && !bus.wr_ready;
                prev_addr  = bus.wr_addr;
                prev_data  = bus.wr_data;
            end
        end
    end

    initial begin : g_watchdog
        #3000000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin : g_main
        int acc0;
        resetn = 1'b0; err_clr = 1'b0; pclk = 1'b0; pstb = 1'b0;
        {r0, g0, b0, r1, g1, b1} = '0;
        {pa, pb, pc, pd, pe} = '0;
        repeat (5) @(negedge display_clock);
        chk("rst_valid", bus.wr_valid, 0);
        chk("rst_addr", bus.wr_addr, 0);
        chk("rst_data", bus.wr_data, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_errs", {err_short, err_overrun}, 0);
        resetn = 1'b1;
        repeat (5) @(negedge display_clock);

        // Short line: 63 columns then STB
        for (int x = 0; x < W; x++) begin
            top[x] = 24'($urandom);
            bot[x] = 24'($urandom);
        end
        drive_line(7, 0, W - 1);
        repeat (6) @(negedge display_clock);
        chk("short_err", err_short, 1);
        repeat (30) @(negedge display_clock);
        chk("short_no_beats", accepts, 0);
        err_clr = 1'b1;
        @(negedge display_clock);
        err_clr = 1'b0;
        @(negedge display_clock);
        chk("short_clr", err_short, 0);

        // Full frame with 1-of-3 backpressure, pinned pixel on row 5
        mode = 2;
        pin_on = 1'b1;
        acc0 = accepts;
        for (int row = 0; row < H/2; row++) drive_row(row, 1'b1);
        drain();
        pin_on = 1'b0;
        chk("frame_accepts", accepts - acc0, 4096);
        chk("frame_done_count", fd_count, 1);
        chk("frame_no_errs", {err_short, err_overrun}, 0);

        // Overrun: two rows parked, third dropped
        mode = 0;
        acc0 = accepts;
        drive_row(4, 1'b1);
        drive_row(5, 1'b1);
        repeat (6) @(negedge display_clock);
        chk("ovr_not_yet", err_overrun, 0);
        drive_row(6, 1'b0);
        repeat (6) @(negedge display_clock);
        chk("ovr_set", err_overrun, 1);
        chk("ovr_stalled", accepts - acc0, 0);
        mode = 1;
        drain();
        chk("ovr_accepts", accepts - acc0, 256);
        chk("ovr_frame_done", fd_count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
